// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: TLBRD, TLBWR, TLBFILL and INVTLB.
// Owns the TLB read port and the write/invalidate strobes.
module tlb_maint_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [4:0]      req_inv_op,
    input  logic [IDXW-1:0] req_index,
    input  logic [9:0]      req_asid,
    input  logic [31:0]     req_va,
    output logic [IDXW-1:0] r_index,
    input  logic            r_e,
    input  logic            r_g,
    input  logic [5:0]      r_ps,
    input  logic [9:0]      r_asid,
    input  logic [18:0]     r_vppn,
    output logic            we,
    output logic [IDXW-1:0] w_index,
    output logic            inv_we,
    output logic [IDXW-1:0] inv_index,
    output logic            rd_valid,
    output logic            done,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_INV  = 2'd3;

    localparam logic [1:0] OP_FILL = 2'd2;
    localparam logic [1:0] OP_INV  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [1:0]      r_op;
    logic [4:0]      r_inv_op;
    logic [IDXW-1:0] r_lat_index;
    logic [9:0]      r_lat_asid;
    logic [18:0]     r_lat_va;
    logic [IDXW-1:0] r_cnt;
    logic [IDXW-1:0] r_fill;

    logic w_accept;
    logic w_last;
    logic w_vmatch;
    logic w_amatch;
    logic w_match;
    logic w_unused;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_last   = (r_cnt == IDXW'(TLBNUM - 1));
    assign w_unused = ^req_va[12:0];

    assign w_vmatch = (r_ps == 6'd21) ?
                      (r_vppn[18:9] == r_lat_va[18:9]) :
                      (r_vppn == r_lat_va);
    assign w_amatch = (r_asid == r_lat_asid);

    // INVTLB match rule for the entry currently on the read port
    always_comb begin
        w_match = 1'b0;
        case (r_inv_op)
            5'd0, 5'd1: w_match = 1'b1;
            5'd2:       w_match = r_g;
            5'd3:       w_match = ~r_g;
            5'd4:       w_match = ~r_g & w_amatch;
            5'd5:       w_match = ~r_g & w_amatch & w_vmatch;
            5'd6:       w_match = (r_g | w_amatch) & w_vmatch;
            default:    w_match = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state: unknown INVTLB ops reuse the one-cycle WR slot as a no-op
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    unique case (req_op)
                        2'd0:    w_next_state = S_RD;
                        2'd1:    w_next_state = S_WR;
                        2'd2:    w_next_state = S_WR;
                        default: w_next_state =
                            (req_inv_op > 5'd6) ? S_WR : S_INV;
                    endcase
                end
            end
            S_RD:    w_next_state = S_IDLE;
            S_WR:    w_next_state = S_IDLE;
            default: w_next_state = w_last ? S_IDLE : S_INV;
        endcase
    end

    // request latch, walk counter and fill pointer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op        <= 2'd0;
            r_inv_op    <= 5'd0;
            r_lat_index <= '0;
            r_lat_asid  <= 10'd0;
            r_lat_va    <= 19'd0;
            r_cnt       <= '0;
            r_fill      <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= req_op;
                r_inv_op    <= req_inv_op;
                r_lat_index <= req_index;
                r_lat_asid  <= req_asid;
                r_lat_va    <= req_va[31:13];
            end
            if (r_state == S_INV) begin
                r_cnt <= r_cnt + IDXW'(1);
            end
            if (r_state == S_WR && r_op == OP_FILL) begin
                r_fill <= r_fill + IDXW'(1);
            end
        end
    end

    // outputs decoded from the current state
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        r_index   = '0;
        we        = 1'b0;
        w_index   = '0;
        inv_we    = 1'b0;
        inv_index = '0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RD: begin
                r_index  = r_lat_index;
                rd_valid = 1'b1;
                done     = 1'b1;
            end
            S_WR: begin
                we      = (r_op != OP_INV);
                w_index = (r_op == OP_INV)  ? '0 :
                          (r_op == OP_FILL) ? r_fill : r_lat_index;
                done    = 1'b1;
            end
            default: begin
                r_index   = r_cnt;
                inv_we    = r_e & w_match;
                inv_index = (r_e & w_match) ? r_cnt : '0;
                done      = w_last;
            end
        endcase
    end

endmodule

// File: doc/tlb_maint_ctrl.md
# tlb_maint_ctrl

Sequencer that owns the TLB's shared read port and write/invalidate strobes and executes TLB maintenance commands (TLBRD, TLBWR, TLBFILL, INVTLB) issued by the write-back stage. It serialises commands, selects the write index (including the TLBFILL round-robin pointer), and walks all entries for INVTLB, clearing matching E bits one entry per cycle. It sits between the WB stage and the TLB array; CSR-sourced write data goes to the TLB directly and does not pass through this block.

## Interface
- TLBNUM, 16, number of TLB entries (power of 2, ≥2)
- IDXW, $clog2(TLBNUM), index width
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  command request
- req_ready  out  1  block can accept (high only in IDLE)
- req_op  in  2  0=TLBRD, 1=TLBWR, 2=TLBFILL, 3=INVTLB
- req_inv_op  in  5  INVTLB op code
- req_index  in  IDXW  TLBIDX.index (TLBRD/TLBWR)
- req_asid  in  10  INVTLB asid operand
- req_va  in  32  INVTLB va operand
- r_index  out  IDXW  TLB read index
- r_e, r_g  in  1 each  read entry E, G
- r_ps  in  6  read entry page size
- r_asid  in  10  read entry ASID
- r_vppn  in  19  read entry VPPN
- we  out  1  TLB write strobe (TLBWR/TLBFILL)
- w_index  out  IDXW  TLB write index
- inv_we  out  1  clear E bit of entry inv_index
- inv_index  out  IDXW  entry to invalidate
- rd_valid  out  1  TLBRD result valid on TLB read outputs this cycle (WB latches CSRs)
- done  out  1  one-cycle pulse: command complete
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RD, WR, INV.
- IDLE: req_ready=1; on req_valid latch op, inv_op, index, asid, va[31:13]; go to RD/WR/INV per req_op. INVTLB with inv_op>6 goes to WR-like no-op: one cycle, done=1, no strobes.
- RD (1 cycle): r_index=latched index; rd_valid=1; done=1; → IDLE.
- WR (1 cycle): we=1; w_index = latched index (TLBWR) or fill_ptr (TLBFILL); done=1; → IDLE. On TLBFILL, fill_ptr increments, wrapping TLBNUM-1→0. fill_ptr is unchanged by all other commands.
- INV: counter cnt runs 0..TLBNUM-1, one per cycle. r_index=cnt, inv_index=cnt, inv_we = r_e & match. Done is asserted with cnt=TLBNUM-1, then → IDLE, cnt→0.
- vmatch: if r_ps==21, r_vppn[18:9]==va[31:22]; otherwise r_vppn==va[31:13].
- amatch: r_asid==asid.
- match by op:
  - 0, 1: 1
  - 2: r_g
  - 3: ~r_g
  - 4: ~r_g & amatch
  - 5: ~r_g & amatch & vmatch
  - 6: (r_g | amatch) & vmatch
- Outside the cycles above, we, inv_we, rd_valid and done are 0. r_index=0 in IDLE and WR; w_index and inv_index=0 when their strobes are low.

## Timing
- Reset (resetn=0 at edge): state=IDLE, cnt=0, fill_ptr=0. Following that edge: req_ready=1, busy=0, all strobes and pulses 0, indices 0.
- Reset mid-walk aborts immediately. No further inv_we, and no done.
- Accept at edge T (req_valid & req_ready). RD/WR: action and done in cycle T+1. INV: entries processed in cycles T+1..T+TLBNUM; done in T+TLBNUM.
- req_ready is low from T+1 through the done cycle. The earliest next accept is the edge ending the cycle after done.
- req_valid while busy is ignored; the requester must hold it. Request fields are sampled only at accept.
- The TLB read is combinational: r_* reflect r_index within the same cycle.
- cnt and fill_ptr are IDXW bits and wrap naturally.

## Test plan
- Reset then TLBFILL ×17 (TLBNUM=16): w_index sequence is 0,1,…,15,0. Each command gives we=1 and done=1 one cycle after accept, and busy=1 only in that cycle.
- TLBRD req_index=5: in cycle T+1, r_index=5, rd_valid=1, done=1. TLBWR req_index=9: we=1, w_index=9, and fill_ptr is unchanged.
- Entries 3 (g=0, asid=0x12, vppn=0x00400, ps=12) and 7 (g=1, vppn=0x00400), others E=0; INVTLB op 5, asid=0x12, va=0x00800000: inv_we only at cnt=3; done at T+16.
- Same table, INVTLB op 6, asid=0x99, va=0x00800000: inv_we only at cnt=7. Op 2: only entry 7. Op 0: entries 3 and 7, not the E=0 entries.
- Entry with ps=21, vppn=0x40000|0x1FF, asid=1, g=0; INVTLB op 5, va=0x80000000, asid=1: match (low vppn bits ignored). With ps=12: no match.
- req_valid held during an INV walk, then resetn pulsed at cnt=8: no inv_we or done afterward; req_ready=1 and fill_ptr=0 after reset. An INVTLB with inv_op=7 gives done at T+1 with no inv_we.
